data_sync: RTL
==============

Name: data_sync

Overview:
- Destination-domain bus synchronizer for single-bit-enable CDC transfers.
- Synchronizes a level enable (BUS_EN) through a multi-flop chain, then detects its rising edge.
- On that edge, captures the quasi-static UNSYNC_BUS and emits a one-cycle ENABLE_PULSE.
- Presents the captured word to the local consumer on a valid/ready interface, with sticky overrun detection.

Parameters:
NUM_STAGES, 2, depth of enable synchronizer chain; legal range >= 2
BUS_WIDTH, 8, width of transferred data bus

Ports:
CLK  input  1  destination-domain clock
RST  input  1  synchronous reset, active-high
UNSYNC_BUS  input  BUS_WIDTH  source-domain data; stable while BUS_EN high and for NUM_STAGES+1 CLK cycles after BUS_EN rises
BUS_EN  input  1  source-domain level enable; asynchronous to CLK
READY  input  1  consumer accepts SYNC_BUS when VALID & READY at a rising CLK edge
CLR_OVERRUN  input  1  clears OVERRUN
SYNC_BUS  output  BUS_WIDTH  captured data word
ENABLE_PULSE  output  1  one-cycle strobe, high in the cycle a new word appears on SYNC_BUS
VALID  output  1  SYNC_BUS holds an unconsumed word
OVERRUN  output  1  sticky; a capture occurred while an unconsumed word was pending

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled only on rising CLK.
- Reset values: RST=1 at an edge clears the sync chain, the edge-detect flop, SYNC_BUS, ENABLE_PULSE, VALID and OVERRUN to 0.
  - Reset dominates all other inputs.
  - Reset mid-transfer discards any in-flight enable or pending word.
- Sync chain: sync_q[0] <= BUS_EN; sync_q[k] <= sync_q[k-1]; en_s = sync_q[NUM_STAGES-1]. Only sync_q[0] samples BUS_EN.
- Edge detect:
  - en_d <= en_s.
  - capture = en_s & ~en_d (combinational).
  - Falling edge of BUS_EN produces no action.
- Latency:
  - BUS_EN first sampled high at edge t0 gives en_s=1 after edge t0+NUM_STAGES-1.
  - At edge t0+NUM_STAGES: SYNC_BUS <= UNSYNC_BUS, ENABLE_PULSE <= 1, VALID <= 1.
  - ENABLE_PULSE returns to 0 at the next edge.
- ENABLE_PULSE is high for exactly one cycle per BUS_EN rising edge seen by the chain.
  - A BUS_EN high for one sampled edge still yields one capture.
  - BUS_EN low for fewer than one sampled edge between highs may merge two transfers into one. This is the source's responsibility; no detection is required.
- SYNC_BUS holds its value between captures, and also after a handshake.
- Handshake FSM:
  - States: IDLE (VALID=0) and HOLD (VALID=1).
  - IDLE, capture -> HOLD.
  - HOLD, READY & ~capture -> IDLE.
  - HOLD, READY & capture -> HOLD with new word (old word consumed, no overrun).
  - HOLD, ~READY & capture -> HOLD, SYNC_BUS overwritten with the newest word, OVERRUN <= 1.
  - HOLD, ~READY & ~capture -> HOLD, all outputs stable.
  - READY in IDLE has no effect.
- OVERRUN:
  - Set only by the ~READY & capture case in HOLD.
  - Cleared by CLR_OVERRUN=1 at an edge.
  - Set and clear in the same cycle: set wins, OVERRUN stays 1.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset check: RST=1 for 3 cycles with BUS_EN=1 and UNSYNC_BUS=8'hFF -> all outputs 0 during reset. After release, with BUS_EN held high, first capture occurs at edge NUM_STAGES+1 post-release: SYNC_BUS=8'hFF, one ENABLE_PULSE.
2. Latency: NUM_STAGES=2, UNSYNC_BUS=8'hA5, BUS_EN rises before edge t0 -> SYNC_BUS=8'hA5, ENABLE_PULSE=1, VALID=1 exactly after edge t0+2. ENABLE_PULSE=0 after t0+3. Repeat with NUM_STAGES=3 -> capture after t0+3.
3. Handshake: after the capture of 8'h3C, hold READY=0 for 5 cycles, then READY=1 for 1 cycle -> VALID stays 1 for 5 cycles and drops after the READY edge. SYNC_BUS remains 8'h3C throughout and after.
4. Overrun: capture 8'h11, keep READY=0, run a second transfer with 8'h22 -> SYNC_BUS=8'h22, OVERRUN=1, VALID=1. Pulse CLR_OVERRUN -> OVERRUN=0. Then assert CLR_OVERRUN in the same cycle as a third overrunning capture (8'h33) -> OVERRUN=1.
5. Simultaneous consume and capture: VALID=1 with 8'h44, READY=1 in the exact cycle capture fires for 8'h55 -> SYNC_BUS=8'h55, VALID=1, OVERRUN=0.
6. Minimum-width and long enables:
   - BUS_EN high for exactly one sampled edge -> exactly one ENABLE_PULSE.
   - BUS_EN held high for 50 cycles -> exactly one pulse.
   - BUS_EN falling -> no pulse.
   - Asserting RST in the cycle between en_s rising and capture -> no capture, all outputs 0.

Source files
------------

// File: rtl/data_sync.sv
// Destination-domain bus synchronizer: syncs a level enable, captures UNSYNC_BUS on its rising edge.
// Latency: capture lands NUM_STAGES edges after BUS_EN is first sampled high; ENABLE_PULSE lasts one cycle.
// Backpressure: a word is held with VALID until READY; a new capture while still held overwrites it and sets sticky OVERRUN.
//
// Ports:
//   CLK, RST             destination clock, synchronous active-high reset
//   UNSYNC_BUS, BUS_EN   source-domain data and level enable (BUS_EN asynchronous to CLK)
//   READY, CLR_OVERRUN   consumer handshake and sticky-flag clear
//   SYNC_BUS, ENABLE_PULSE, VALID, OVERRUN   registered outputs
module data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_EN,
    input  logic                 READY,
    input  logic                 CLR_OVERRUN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 VALID,
    output logic                 OVERRUN
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  en_dly_q, en_dly_d;
    logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
    logic                  pulse_q, pulse_d;
    logic                  overrun_q, overrun_d;
    state_t                state_q, state_d;

    logic en_s;
    logic capture;
    logic set_overrun;

    // Only the first stage ever sees the asynchronous BUS_EN.
    assign en_s    = sync_q[NUM_STAGES-1];
    assign capture = en_s & ~en_dly_q;

    // A capture onto a word the consumer has not taken loses that word.
    assign set_overrun = (state_q == HOLD) & capture & ~READY;

    always_comb begin
        sync_d     = {sync_q[NUM_STAGES-2:0], BUS_EN};
        en_dly_d   = en_s;
        sync_bus_d = sync_bus_q;
        pulse_d    = 1'b0;
        state_d    = state_q;
        // Set wins over a simultaneous clear.
        overrun_d  = set_overrun | (overrun_q & ~CLR_OVERRUN);

        if (capture) begin
            sync_bus_d = UNSYNC_BUS;
            pulse_d    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A capture keeps us in HOLD whether or not the old word was taken.
                if (!capture && READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (RST) begin
            sync_d     = '0;
            en_dly_d   = 1'b0;
            sync_bus_d = '0;
            pulse_d    = 1'b0;
            overrun_d  = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        sync_q     <= sync_d;
        en_dly_q   <= en_dly_d;
        sync_bus_q <= sync_bus_d;
        pulse_q    <= pulse_d;
        overrun_q  <= overrun_d;
        state_q    <= state_d;
    end

    assign SYNC_BUS     = sync_bus_q;
    assign ENABLE_PULSE = pulse_q;
    assign VALID        = (state_q == HOLD);
    assign OVERRUN      = overrun_q;

endmodule
